bcd_bin: RTL and testbench
==========================

Name: bcd_bin

Overview:
Sequential BCD-to-binary converter, the inverse of the existing binary-to-BCD display path. It uses reverse double dabble: one shift-right-and-correct iteration per clock. It accepts N_DIG packed BCD digits (hundreds/tens/units by default) from the keypad/operand-entry path. It returns the binary value plus overflow and error flags for loading into the 8-bit datapath.

Parameters:
- N_DIG, 3, number of BCD digits; digit 0 is the units digit and sits in the LSBs.
- W_BIN, 10, result width and iteration count. Must be >= ceil(log2(10^N_DIG)).
- W_DATA, 8, datapath width. Used as the overflow threshold: ovf is set when the result is >= 2^W_DATA.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, synchronous reset, active-low.
- start, in, 1, conversion request; sampled only in IDLE.
- bcd_in, in, 4*N_DIG, packed BCD operand; bits [3:0] are the units digit.
- busy, out, 1, high while a conversion is in progress.
- done, out, 1, single-cycle pulse: result valid.
- binario, out, W_BIN, converted value; held until the next accepted start.
- ovf, out, 1, result does not fit in W_DATA bits; held with binario.
- err, out, 1, invalid digit (>9) detected; held with binario.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst_n` is synchronous and active-low. While rst_n=0 at a rising edge:
  - state goes to IDLE;
  - busy=0, done=0, binario=0, ovf=0, err=0;
  - internal shift register and counter are cleared.
- Reset mid-conversion aborts the conversion with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at edge E0, capture bcd_in into the digit register, clear the bin register, clear the counter, set busy=1 and go to SHIFT.
  - With start=0, remain in IDLE.
- SHIFT (edges E1..E_W_BIN), one iteration per edge:
  - Shift the concatenation {digits, bin} right by one. The LSB of digit 0 enters the MSB of bin, and a 0 enters the top digit.
  - Then, in the same edge, each digit >=8 has 3 subtracted (4-bit, no borrow across digits).
  - The counter increments.
  - At the edge completing iteration W_BIN (E10 by default): load binario from bin, set ovf = (bin >= 2^W_DATA), set err=0, busy=0, done=1, and go to DONE.
- DONE: lasts one cycle. done clears at the next edge and the state returns to IDLE.
  - start=1 in the DONE cycle is accepted exactly as in IDLE (back-to-back conversions, one idle-free cycle).
- Latency: done is high in the cycle after E_W_BIN, i.e. 10 edges after the start-sampling edge by default. Throughput is one conversion per W_BIN+1 cycles.
- start while busy=1 is ignored: no restart and no queuing.
- bcd_in is sampled only at E0; later changes have no effect.
- binario/ovf/err keep their previous values during a new conversion and update only on the done edge.
- ovf only flags; it does not alter binario.

Optional Feature:
- BCD_DIGIT_CHK_EN defined:
  - At E0, any digit >9 sets err=1, binario=0, ovf=0, done=1 at E1 (state DONE), with no SHIFT phase.
  - busy is high for exactly one cycle.
- Not defined:
  - err is tied 0.
  - Invalid digits are processed by the same algorithm. The result is deterministic and equal to the bench reference model of the algorithm, and is not range-checked.

Decomposition:
- Shared package bcd_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - the BCD digit width constant (4);
  - the correction constants (threshold 8, subtrahend 3);
  - a function computing the minimum W_BIN for N_DIG.
- One natural sub-module: bcd_corr_digit, combinational, 4-bit in, 4-bit out (subtract 3 if >=8). It is instantiated N_DIG times in a generate loop.

Test Plan:
- bcd_in=0x000, start pulse -> done at E0+10, binario=0, ovf=0, err=0; busy high for E0..E10.
- bcd_in=0x255 -> binario=255 (0x0FF), ovf=0; then 0x256 -> binario=256 (0x100), ovf=1.
- bcd_in=0x999 -> binario=999 (0x3E7), ovf=1; start re-asserted in the DONE cycle with 0x042 -> second done 11 cycles after the first, binario=42.
- With BCD_DIGIT_CHK_EN: bcd_in=0x1A3 -> done at E1, err=1, binario=0. Without the macro: err=0, binario equals the reference-model value.
- start pulsed at E3 with bcd_in changed to 0x111 during a conversion of 0x128 -> ignored, binario=128.
- rst_n=0 at E5 of a conversion -> no done, all outputs 0 next cycle. A new start of 0x007 afterward -> binario=7.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: definitions shared by the BCD-to-binary converter.
//   state_t    - controller states (IDLE / SHIFT / DONE)
//   DIG_W      - width of one BCD digit
//   CORR_THR   - a digit at or above this value is corrected after a shift
//   CORR_SUB   - amount subtracted from a digit that needs correcting
//   DIG_MAX    - largest legal BCD digit value
//   min_w_bin  - smallest binary width able to hold any N_DIG-digit decimal value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIG_W    = 4;
  localparam int CORR_THR = 8;
  localparam int CORR_SUB = 3;
  localparam int DIG_MAX  = 9;

  // ceil(log2(10^n_dig)): bits needed for the value 10^n_dig - 1
  function automatic int min_w_bin(input int n_dig);
    longint p = 1;
    int     w = 0;
    for (int i = 0; i < n_dig; i++) p = p * 10;
    while ((longint'(1) << w) < p) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_bin_if.sv
// bcd_bin_if: request/result bundle of the BCD-to-binary converter.
//   start   - conversion request (master -> slave)
//   bcd_in  - packed BCD operand, units digit in [3:0] (master -> slave)
//   busy    - conversion in progress (slave -> master)
//   done    - one-cycle result-valid pulse (slave -> master)
//   binario - converted value (slave -> master)
//   ovf     - result does not fit the datapath width (slave -> master)
//   err     - invalid BCD digit seen (slave -> master)
// The slave modport is the converter; the master is the requester.
interface bcd_bin_if
  import bcd_pkg::*;
#(
  parameter int N_DIG = 3,
  parameter int W_BIN = 10
);
  logic                     start;
  logic [DIG_W*N_DIG-1:0]   bcd_in;
  logic                     busy;
  logic                     done;
  logic [W_BIN-1:0]         binario;
  logic                     ovf;
  logic                     err;

  modport master (output start, bcd_in,
                  input  busy, done, binario, ovf, err);
  modport slave  (input  start, bcd_in,
                  output busy, done, binario, ovf, err);
endinterface

// File: rtl/bcd_corr_digit.sv
// bcd_corr_digit: per-digit correction of reverse double dabble.
// After the right shift a digit that held an odd-weighted tens carry reads
// 8 or more; subtracting 3 restores a valid BCD digit (halving 10 gives 5,
// but the shift deposited 8).
//   i_dig - shifted digit
//   o_dig - corrected digit
module bcd_corr_digit
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] i_dig,
  output logic [DIG_W-1:0] o_dig
);
  assign o_dig = (i_dig >= DIG_W'(CORR_THR)) ? (i_dig - DIG_W'(CORR_SUB)) : i_dig;
endmodule

// File: rtl/bcd_bin.sv
// bcd_bin: sequential BCD-to-binary converter (reverse double dabble),
// one shift-and-correct iteration per clock, W_BIN iterations per operand.
//   clk   - system clock, rising edge
//   rst_n - synchronous reset, active low
//   bus   - bcd_bin_if.slave: start/bcd_in in; busy/done/binario/ovf/err out
// Parameters: N_DIG digits, W_BIN result width / iteration count,
// W_DATA datapath width used as the overflow threshold.
// Optional build macro BCD_DIGIT_CHK_EN: reject operands holding a digit
// above 9 (err=1, binario=0) one cycle after start instead of converting.
module bcd_bin
  import bcd_pkg::*;
#(
  parameter int N_DIG  = 3,
  parameter int W_BIN  = 10,
  parameter int W_DATA = 8
)(
  input  logic     clk,
  input  logic     rst_n,
  bcd_bin_if.slave bus
);
  localparam int W_DIGS = DIG_W * N_DIG;
  localparam int CW     = $clog2(W_BIN + 1);

  state_t           r_state;
  logic [W_DIGS-1:0] r_dig;
  logic [W_BIN-1:0]  r_bin;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [W_BIN-1:0]  r_binario;
  logic              r_ovf;
  logic              r_err;

  logic [W_DIGS-1:0] w_dig_sh;
  logic [W_DIGS-1:0] w_dig_nxt;
  logic [W_BIN-1:0]  w_bin_nxt;
  logic              w_last;
  logic              w_ovf;

  // Digit 0's LSB drops into the bin MSB; a zero enters the top digit.
  assign {w_dig_sh, w_bin_nxt} = {r_dig, r_bin} >> 1;

  for (genvar g = 0; g < N_DIG; g++) begin : g_corr
    bcd_corr_digit u_corr (
      .i_dig (w_dig_sh [g*DIG_W +: DIG_W]),
      .o_dig (w_dig_nxt[g*DIG_W +: DIG_W])
    );
  end

`ifdef BCD_DIGIT_CHK_EN
  logic [N_DIG-1:0] w_bad;
  for (genvar g = 0; g < N_DIG; g++) begin : g_chk
    assign w_bad[g] = r_dig[g*DIG_W +: DIG_W] > DIG_W'(DIG_MAX);
  end
`endif

  assign w_last = (r_cnt == CW'(W_BIN - 1));
  assign w_ovf  = (64'(w_bin_nxt) >> W_DATA) != 64'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_dig     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_binario <= '0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new start just like IDLE, so conversions can
        // run back to back with only the done cycle between them.
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_dig   <= bus.bcd_in;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
`ifdef BCD_DIGIT_CHK_EN
          // r_dig still holds the raw operand before the first iteration.
          if (r_cnt == '0 && |w_bad) begin
            r_binario <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else
`endif
          begin
            r_dig <= w_dig_nxt;
            r_bin <= w_bin_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_binario <= w_bin_nxt;
              r_ovf     <= w_ovf;
              r_err     <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.binario = r_binario;
  assign bus.ovf     = r_ovf;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_bcd_bin.sv
// tb_bcd_bin: table of directed vectors, hand-written multi-cycle sequences
// (back-to-back, ignored start, mid-conversion reset) and random operands
// checked against a decimal-arithmetic reference model.
module tb_bcd_bin;
  import bcd_pkg::*;

  localparam int N_DIG  = 3;
  localparam int W_BIN  = min_w_bin(N_DIG);
  localparam int W_DATA = 8;
  localparam int W_IN   = DIG_W * N_DIG;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  bcd_bin_if #(.N_DIG(N_DIG), .W_BIN(W_BIN)) bus ();

  bcd_bin #(.N_DIG(N_DIG), .W_BIN(W_BIN), .W_DATA(W_DATA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W_IN-1:0] bcd;
    int              exp_bin;
    bit              exp_ovf;
    bit              exp_err;
    int              exp_lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: decimal value of the digits. Operands with a digit above 9
  // are either rejected (checking build) or run through the shift/correct
  // rule on an array of digit values.
  function automatic void ref_model(input logic [W_IN-1:0] bcd, output int bin,
                                    output bit ovf, output bit err, output int lat);
    int d[N_DIG];
    bit valid = 1'b1;
    int pw = 1;
    for (int i = 0; i < N_DIG; i++) begin
      d[i] = int'(bcd[4*i +: 4]);
      if (d[i] > 9) valid = 1'b0;
    end
    err = 1'b0;
    lat = W_BIN;
    bin = 0;
`ifdef BCD_DIGIT_CHK_EN
    if (!valid) begin
      ovf = 1'b0;
      err = 1'b1;
      lat = 1;
      return;
    end
`endif
    if (valid) begin
      for (int i = 0; i < N_DIG; i++) begin
        bin += d[i] * pw;
        pw  *= 10;
      end
    end else begin
      for (int s = 0; s < W_BIN; s++) begin
        bin |= (d[0] & 1) << s;
        for (int i = 0; i < N_DIG; i++) begin
          d[i] = d[i] >> 1;
          if (i < N_DIG - 1) d[i] = d[i] | ((d[i+1] & 1) << 3);
        end
        for (int i = 0; i < N_DIG; i++)
          if (d[i] >= 8) d[i] = d[i] - 3;
      end
    end
    ovf = (bin >= (1 << W_DATA));
  endfunction

  // Counts edges from now until done rises (bounded), and cycles with busy.
  task automatic wait_done(output int lat, output int busy_cyc, output bit got);
    lat = 0; busy_cyc = 0; got = 1'b0;
    for (int k = 1; k <= 30 && !got; k++) begin
      if (bus.busy) busy_cyc++;
      tick();
      if (bus.done) begin
        got = 1'b1;
        lat = k;
      end
    end
  endtask

  task automatic run_conv(input logic [W_IN-1:0] bcd, output int lat,
                          output int busy_cyc, output bit got);
    bus.bcd_in = bcd;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    wait_done(lat, busy_cyc, got);
  endtask

  task automatic check_conv(input string nm, input vec_t v);
    int lat, bc;
    bit got;
    run_conv(v.bcd, lat, bc, got);
    chk({nm, " done_seen"}, got, 1);
    chk({nm, " latency"}, lat, v.exp_lat);
    chk({nm, " busy_cycles"}, bc, v.exp_lat);
    chk({nm, " binario"}, bus.binario, v.exp_bin);
    chk({nm, " ovf"}, bus.ovf, v.exp_ovf);
    chk({nm, " err"}, bus.err, v.exp_err);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   lat, bc, t_first, nd;
    bit   got;

    n_tests = 0;
    n_fail  = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;

    // reset state
    repeat (3) tick();
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst binario", bus.binario, 0);
    chk("rst ovf", bus.ovf, 0);
    chk("rst err", bus.err, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle done", bus.done, 0);

    // directed table
    tbl.push_back('{12'h000,   0, 1'b0, 1'b0, 10});
    tbl.push_back('{12'h255, 255, 1'b0, 1'b0, 10});
    tbl.push_back('{12'h256, 256, 1'b1, 1'b0, 10});
    tbl.push_back('{12'h999, 999, 1'b1, 1'b0, 10});
    tbl.push_back('{12'h010,  10, 1'b0, 1'b0, 10});
    tbl.push_back('{12'h128, 128, 1'b0, 1'b0, 10});
    v.bcd = 12'h1A3;
    ref_model(v.bcd, v.exp_bin, v.exp_ovf, v.exp_err, v.exp_lat);
`ifdef BCD_DIGIT_CHK_EN
    v.exp_bin = 0; v.exp_ovf = 1'b0; v.exp_err = 1'b1; v.exp_lat = 1;
`endif
    tbl.push_back(v);
    foreach (tbl[i]) begin
      check_conv($sformatf("vec%0d_%03h", i, tbl[i].bcd), tbl[i]);
      repeat (2) tick();
    end

    // back-to-back: 999 then 042 started in the done cycle
    run_conv(12'h999, lat, bc, got);
    chk("b2b first done", got, 1);
    chk("b2b first bin", bus.binario, 999);
    t_first = cyc;
    bus.bcd_in = 12'h042;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    chk("b2b second busy", bus.busy, 1);
    chk("b2b hold bin", bus.binario, 999);
    chk("b2b hold ovf", bus.ovf, 1);
    wait_done(lat, bc, got);
    chk("b2b second done", got, 1);
    chk("b2b spacing", cyc - t_first, 11);
    chk("b2b second bin", bus.binario, 42);
    chk("b2b second ovf", bus.ovf, 0);
    repeat (2) tick();

    // start during a conversion is ignored, bcd_in change has no effect
    bus.bcd_in = 12'h128;
    bus.start  = 1'b1;
    tick();                       // E0
    bus.start  = 1'b0;
    repeat (2) tick();            // E1, E2
    bus.bcd_in = 12'h111;
    bus.start  = 1'b1;
    tick();                       // E3
    bus.start  = 1'b0;
    chk("ign busy", bus.busy, 1);
    wait_done(lat, bc, got);
    chk("ign done", got, 1);
    chk("ign latency", lat + 3, 10);
    chk("ign bin", bus.binario, 128);
    repeat (3) tick();
    chk("ign no restart", bus.busy, 0);

    // reset at E5 aborts with no done pulse
    bus.bcd_in = 12'h999;
    bus.start  = 1'b1;
    tick();                       // E0
    bus.start  = 1'b0;
    repeat (4) tick();            // E1..E4
    rst_n = 1'b0;
    tick();                       // E5
    rst_n = 1'b1;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort binario", bus.binario, 0);
    chk("abort ovf", bus.ovf, 0);
    chk("abort err", bus.err, 0);
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.done) nd++;
    end
    chk("abort no done", nd, 0);
    check_conv("after_rst_007", '{12'h007, 7, 1'b0, 1'b0, 10});

    // random operands against the reference model
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        v.bcd = W_IN'($urandom);
      end else begin
        for (int i = 0; i < N_DIG; i++) v.bcd[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      ref_model(v.bcd, v.exp_bin, v.exp_ovf, v.exp_err, v.exp_lat);
      check_conv($sformatf("rnd%0d_%03h", n, v.bcd), v);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
